// File: rtl/aq_vlsu_ld_align_buffer.sv
// Vector load alignment buffer: packs rotated, partial load beats into
// element-contiguous 64-bit write-back words behind a single output register.
module aq_vlsu_ld_align_buffer (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        rtu_yy_xx_flush,
    input  logic        ld_data_vld,
    input  logic [63:0] ld_data,
    input  logic [2:0]  ld_rot,
    input  logic [3:0]  ld_bytes,
    input  logic        ld_last,
    output logic        ld_data_ready,
    output logic        vreg_wdata_vld,
    output logic [63:0] vreg_wdata,
    output logic [7:0]  vreg_wdata_mask,
    output logic [2:0]  vreg_wdata_idx,
    output logic        vreg_wdata_last,
    input  logic        vreg_wdata_ready
);

    typedef enum logic [0:0] {ST_ACC = 1'b0, ST_FLUSH = 1'b1} state_e;

    state_e       state_r, state_nxt_s;
    logic [63:0]  acc_r, acc_nxt_s;
    logic [2:0]   acc_cnt_r, acc_cnt_nxt_s;
    logic         vld_r, last_r;
    logic [63:0]  wdata_r;
    logic [7:0]   mask_r;
    logic [2:0]   idx_r, idx_nxt_r;

    logic [3:0]   combined_s;
    logic [63:0]  extract_s;
    logic [127:0] merged_s;
    logic         slot_free_s, accept_s;
    logic         load_s, load_last_s;
    logic [63:0]  load_data_s;
    logic [7:0]   load_mask_s;

    // Byte enable with the low n bytes set (n >= 8 saturates to all bytes).
    function automatic logic [7:0] low_mask(input logic [3:0] n);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) m[i] = 1'b1;
            else           m[i] = 1'b0;
        end
        return m;
    endfunction

    // Expand a byte enable into a 64-bit bit mask.
    function automatic logic [63:0] byte_expand(input logic [7:0] m);
        logic [63:0] e;
        e = 64'h0;
        for (int i = 0; i < 8; i++) e[i*8 +: 8] = {8{m[i]}};
        return e;
    endfunction

    // Datapath: extract useful bytes and append them after the accumulated bytes.
    always_comb begin
        combined_s  = {1'b0, acc_cnt_r} + ld_bytes;
        extract_s   = (ld_data >> {ld_rot, 3'b000}) & byte_expand(low_mask(ld_bytes));
        merged_s    = {64'h0, acc_r} | ({64'h0, extract_s} << {acc_cnt_r, 3'b000});
        slot_free_s = !vld_r || vreg_wdata_ready;
        ld_data_ready = (state_r == ST_ACC) && slot_free_s;
        accept_s    = ld_data_vld && ld_data_ready;
    end

    // Next-state and slot-load decision.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        acc_cnt_nxt_s = acc_cnt_r;
        load_s        = 1'b0;
        load_last_s   = 1'b0;
        load_data_s   = 64'h0;
        load_mask_s   = 8'h00;
        case (state_r)
            ST_ACC: begin
                if (accept_s) begin
                    if (!ld_last && (combined_s < 4'd8)) begin
                        acc_nxt_s     = merged_s[63:0];
                        acc_cnt_nxt_s = combined_s[2:0];
                    end else if (ld_last && (combined_s <= 4'd8)) begin
                        load_s        = 1'b1;
                        load_last_s   = 1'b1;
                        load_data_s   = merged_s[63:0];
                        load_mask_s   = low_mask(combined_s);
                        acc_nxt_s     = 64'h0;
                        acc_cnt_nxt_s = 3'd0;
                    end else begin
                        // Full word out; bytes past position 7 wrap to the accumulator base.
                        load_s        = 1'b1;
                        load_data_s   = merged_s[63:0];
                        load_mask_s   = 8'hff;
                        acc_nxt_s     = merged_s[127:64];
                        acc_cnt_nxt_s = combined_s[2:0];
                        if (ld_last) state_nxt_s = ST_FLUSH;
                        else         state_nxt_s = ST_ACC;
                    end
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_FLUSH: begin
                if (slot_free_s) begin
                    load_s        = 1'b1;
                    load_last_s   = 1'b1;
                    load_data_s   = acc_r;
                    load_mask_s   = low_mask({1'b0, acc_cnt_r});
                    acc_nxt_s     = 64'h0;
                    acc_cnt_nxt_s = 3'd0;
                    state_nxt_s   = ST_ACC;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_ACC;
            end
        endcase
    end

    // State, accumulator and output slot registers; flush clears like reset.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b || rtu_yy_xx_flush) begin
            state_r   <= ST_ACC;
            acc_r     <= 64'h0;
            acc_cnt_r <= 3'd0;
            vld_r     <= 1'b0;
            wdata_r   <= 64'h0;
            mask_r    <= 8'h00;
            idx_r     <= 3'd0;
            idx_nxt_r <= 3'd0;
            last_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            acc_cnt_r <= acc_cnt_nxt_s;
            if (load_s) begin
                vld_r     <= 1'b1;
                wdata_r   <= load_data_s;
                mask_r    <= load_mask_s;
                last_r    <= load_last_s;
                idx_r     <= idx_nxt_r;
                idx_nxt_r <= load_last_s ? 3'd0 : idx_nxt_r + 3'd1;
            end else if (vreg_wdata_ready) begin
                vld_r <= 1'b0;
            end else begin
                vld_r <= vld_r;
            end
        end
    end

    assign vreg_wdata_vld  = vld_r;
    assign vreg_wdata      = wdata_r;
    assign vreg_wdata_mask = mask_r;
    assign vreg_wdata_idx  = idx_r;
    assign vreg_wdata_last = last_r;

endmodule

// File: tb/tb_aq_vlsu_ld_align_buffer.sv
// Directed scoreboard bench for the load alignment buffer.
module tb_aq_vlsu_ld_align_buffer;

    logic        clk = 1'b0;
    logic        cpurst_b, flush, ld_data_vld, ld_last, ld_data_ready;
    logic [63:0] ld_data;
    logic [2:0]  ld_rot;
    logic [3:0]  ld_bytes;
    logic        vld, last, vready;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [2:0]  idx;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  mask;
        logic [2:0]  idx;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    aq_vlsu_ld_align_buffer dut (
        .forever_cpuclk  (clk),
        .cpurst_b        (cpurst_b),
        .rtu_yy_xx_flush (flush),
        .ld_data_vld     (ld_data_vld),
        .ld_data         (ld_data),
        .ld_rot          (ld_rot),
        .ld_bytes        (ld_bytes),
        .ld_last         (ld_last),
        .ld_data_ready   (ld_data_ready),
        .vreg_wdata_vld  (vld),
        .vreg_wdata      (wdata),
        .vreg_wdata_mask (mask),
        .vreg_wdata_idx  (idx),
        .vreg_wdata_last (last),
        .vreg_wdata_ready(vready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] m, input logic [2:0] i, input logic l);
        word_t w;
        w.data = d; w.mask = m; w.idx = i; w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [2:0] r, input logic [3:0] b, input logic l);
        int n;
        n = 0;
        ld_data_vld = 1'b1; ld_data = d; ld_rot = r; ld_bytes = b; ld_last = l;
        @(negedge clk);
        while (!ld_data_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("beat_accept", {63'h0, ld_data_ready}, 64'h1);
        @(posedge clk);
        #1;
        ld_data_vld = 1'b0;
    endtask

    // Scoreboard: compare each handshaken output word with the oldest expectation.
    always @(negedge clk) begin
        if (cpurst_b && !flush && vld && vready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word observed=%h expected=none", wdata);
            end
            if (exp_q.size() != 0) begin
                word_t w;
                w = exp_q.pop_front();
                chk("out_data", wdata, w.data);
                chk("out_mask", {56'h0, mask}, {56'h0, w.mask});
                chk("out_idx",  {61'h0, idx},  {61'h0, w.idx});
                chk("out_last", {63'h0, last}, {63'h0, w.last});
            end
        end
    end

    initial begin
        cpurst_b = 1'b0; flush = 1'b0; vready = 1'b1;
        ld_data_vld = 1'b0; ld_data = 64'h0; ld_rot = 3'd0; ld_bytes = 4'd1; ld_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 cpurst_b = 1'b1;
        @(negedge clk);
        chk("rst_vld",   {63'h0, vld}, 64'h0);
        chk("rst_data",  wdata, 64'h0);
        chk("rst_mask",  {56'h0, mask}, 64'h0);
        chk("rst_idx",   {61'h0, idx}, 64'h0);
        chk("rst_last",  {63'h0, last}, 64'h0);
        chk("rst_ready", {63'h0, ld_data_ready}, 64'h1);
        @(posedge clk); #1;

        // Aligned two-beat load
        push(64'h0706050403020100, 8'hff, 3'd0, 1'b0);
        push(64'h0f0e0d0c0b0a0908, 8'hff, 3'd1, 1'b1);
        drive_beat(64'h0706050403020100, 3'd0, 4'd8, 1'b0);
        drive_beat(64'h0f0e0d0c0b0a0908, 3'd0, 4'd8, 1'b1);

        // Unaligned start with remainder flushed after the last beat
        push(64'hb4b3b2b1b0a7a6a5, 8'hff, 3'd0, 1'b0);
        push(64'h0000000000b7b6b5, 8'h07, 3'd1, 1'b1);
        drive_beat(64'ha7a6a5a4a3a2a1a0, 3'd5, 4'd3, 1'b0);
        drive_beat(64'hb7b6b5b4b3b2b1b0, 3'd0, 4'd8, 1'b1);
        @(negedge clk);
        chk("flush_state_ready", {63'h0, ld_data_ready}, 64'h0);
        repeat (3) @(posedge clk); #1;

        // Short single last beat
        push(64'h0000000000554433, 8'h07, 3'd0, 1'b1);
        drive_beat(64'h8877665544332211, 3'd2, 4'd3, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Backpressure: held word stays stable, next beat waits
        vready = 1'b0;
        push(64'he7e6e5e4e3e2e1e0, 8'hff, 3'd0, 1'b0);
        push(64'hf7f6f5f4f3f2f1f0, 8'hff, 3'd1, 1'b1);
        drive_beat(64'he7e6e5e4e3e2e1e0, 3'd0, 4'd8, 1'b0);
        ld_data_vld = 1'b1; ld_data = 64'hf7f6f5f4f3f2f1f0; ld_rot = 3'd0; ld_bytes = 4'd8; ld_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_data",  wdata, 64'he7e6e5e4e3e2e1e0);
            chk("bp_vld",   {63'h0, vld}, 64'h1);
            chk("bp_ready", {63'h0, ld_data_ready}, 64'h0);
        end
        @(posedge clk); #1;
        vready = 1'b1;
        drive_beat(64'hf7f6f5f4f3f2f1f0, 3'd0, 4'd8, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Flush with five bytes accumulated and a word pending
        drive_beat(64'h1111111111111111, 3'd0, 4'd5, 1'b0);
        vready = 1'b0;
        drive_beat(64'h2222222222222222, 3'd0, 4'd8, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_vld",   {63'h0, vld}, 64'h0);
        chk("fl_idx",   {61'h0, idx}, 64'h0);
        chk("fl_data",  wdata, 64'h0);
        chk("fl_mask",  {56'h0, mask}, 64'h0);
        chk("fl_ready", {63'h0, ld_data_ready}, 64'h1);
        @(posedge clk); #1;
        vready = 1'b1;
        push(64'h3736353433323130, 8'hff, 3'd0, 1'b1);
        drive_beat(64'h3736353433323130, 3'd0, 4'd8, 1'b1);

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_vlsu_ld_align_buffer.md
AQ_VLSU_LD_ALIGN_BUFFER -- requirements
Module: aq_vlsu_ld_align_buffer

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 64 bits (8 bytes).
REQ-002 forever_cpuclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 cpurst_b  input  1  reset, synchronous and active-low.
REQ-004 rtu_yy_xx_flush  input  1  pipeline flush; synchronously discards all buffered state.
REQ-005 ld_data_vld  input  1  load read beat valid.
REQ-006 ld_data  input  64  raw memory read dword.
REQ-007 ld_rot  input  3  byte offset of first useful byte in ld_data.
REQ-008 ld_bytes  input  4  useful byte count this beat, 1..8; ld_rot+ld_bytes<=8 guaranteed by sender.
REQ-009 ld_last  input  1  beat is last of the load sequence.
REQ-010 ld_data_ready  output  1  beat accepted when ld_data_vld && ld_data_ready.
REQ-011 vreg_wdata_vld  output  1  aligned write-back word valid.
REQ-012 vreg_wdata  output  64  aligned element-contiguous data, byte 0 = oldest byte.
REQ-013 vreg_wdata_mask  output  8  byte enables for vreg_wdata.
REQ-014 vreg_wdata_idx  output  3  word index within current sequence.
REQ-015 vreg_wdata_last  output  1  word is final word of sequence.
REQ-016 vreg_wdata_ready  input  1  consumer accepts output when vreg_wdata_vld && vreg_wdata_ready.

Function
REQ-017 Extraction: beat contributes bytes ld_data[ld_rot .. ld_rot+ld_bytes-1], appended in order at accumulator byte position acc_cnt (0..7).
REQ-018 combined = acc_cnt + ld_bytes (4-bit, 1..15); bytes landing at position >=8 SHALL wrap into accumulator positions combined-8.. from 0.
REQ-019 Output slot is a single register stage; slot_free = !vreg_wdata_vld || vreg_wdata_ready.
REQ-020 FSM states: ACC (accumulating, acc_cnt 0..7) and FLUSH (remainder pending after last beat); reset state ACC.
REQ-021 ld_data_ready SHALL equal (state==ACC) && slot_free; combinational, no dependence on ld_data_vld.
REQ-022 Accepted beat, !ld_last, combined<8: no output; acc_cnt<=combined.
REQ-023 Accepted beat, !ld_last, combined>=8: load slot with 8 full bytes, mask 8'hff, last 0; acc_cnt<=combined-8 holding wrapped bytes.
REQ-024 Accepted beat, ld_last, combined<=8: load slot with merged bytes, mask = low combined bits set, last 1; acc_cnt<=0.
REQ-025 Accepted beat, ld_last, combined>8: load slot with full word, mask 8'hff, last 0; acc_cnt<=combined-8; go FLUSH.
REQ-026 In FLUSH when slot_free: load slot with remainder, mask low acc_cnt bits, last 1; acc_cnt<=0; go ACC; one-cycle minimum FLUSH residency.
REQ-027 Output fields SHALL hold stable while vreg_wdata_vld && !vreg_wdata_ready; vreg_wdata_vld clears on handshake when no new word is loaded.
REQ-028 vreg_wdata_idx SHALL increment (mod 8) on each word loaded into slot, and reset to 0 on the word after a word with last=1.
REQ-029 Back-to-back throughput SHALL be one beat per cycle when vreg_wdata_ready stays high.
REQ-030 Unused mask-disabled bytes of vreg_wdata SHALL be driven 0.

Reset
REQ-031 On cpurst_b low at clock edge: state ACC, acc_cnt 0, accumulator 0, vreg_wdata_vld 0, vreg_wdata 0, mask 0, idx 0, last 0.
REQ-032 rtu_yy_xx_flush SHALL apply identical clearing, lower priority than reset, higher than any beat or handshake in the same cycle; beat presented that cycle is dropped.
REQ-033 ld_data_ready after reset SHALL be 1.

Verification
REQ-034 Aligned: 2 beats rot=0 bytes=8, data 0x0706050403020100 then 0x0F0E..08, last on 2nd -> words 0x0706050403020100 mask ff idx0, 0x0F0E0D0C0B0A0908 mask ff idx1 last.
REQ-035 Unaligned: beat rot=5 bytes=3 (bytes A5..A7), beat rot=0 bytes=8 last -> word {B4..B0,A7,A6,A5} mask ff, then FLUSH word {B7,B6,B5} mask 07 last; ld_data_ready low during FLUSH.
REQ-036 Short last: single beat rot=2 bytes=3 last -> word bytes0..2 = input bytes2..4, mask 07, last 1, upper bytes 0.
REQ-037 Backpressure: vreg_wdata_ready low 4 cycles with word pending -> outputs stable, ld_data_ready 0, no beat lost after release.
REQ-038 Flush mid-sequence with acc_cnt=5 and slot valid -> next cycle vreg_wdata_vld 0, acc_cnt 0, idx 0; following sequence outputs clean.
